// File: rtl/soc_gpio_input_filter.sv
// GPIO pad conditioning: per-pin synchronizer plus optional debounce on a shared sample tick.
// Unfiltered latency SYNC_STAGES+1 edges; filtered adds DEBOUNCE_CNT consecutive mismatching ticks.
module soc_gpio_input_filter #(
  parameter int PORT_COUNT   = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int PRESCALE     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [32*PORT_COUNT-1:0] pin_in,
  input  logic [32*PORT_COUNT-1:0] filter_en,
  output logic [32*PORT_COUNT-1:0] gpio_in,
  output logic                    sample_tick
);
  localparam int W  = 32 * PORT_COUNT;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

  if (PORT_COUNT < 1 || PORT_COUNT > 16) begin : g_bad_port_count
    $error("soc_gpio_input_filter: PORT_COUNT must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("soc_gpio_input_filter: SYNC_STAGES must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("soc_gpio_input_filter: PRESCALE must be >= 1");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce_cnt
    $error("soc_gpio_input_filter: DEBOUNCE_CNT must be >= 1");
  end

  logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [PW-1:0]                 ps_q, ps_d;
  logic                          tick_q, tick_d;
  logic [W-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [W-1:0]                  gpio_q, gpio_d;
  logic [W-1:0]                  sync_out;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign gpio_in     = gpio_q;
  assign sample_tick = tick_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Tick is registered so it is low in reset even when PRESCALE is 1.
  always_comb begin
    ps_d   = (ps_q == PS_LAST) ? '0 : ps_q + PW'(1);
    tick_d = (ps_d == PS_LAST);
  end

  always_comb begin
    gpio_d = gpio_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < W; i++) begin
      if (!filter_en[i]) begin
        gpio_d[i] = sync_out[i];
        cnt_d[i]  = '0;
      end else if (tick_q) begin
        if (sync_out[i] == gpio_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          gpio_d[i] = sync_out[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      sync_q <= '0;
      ps_q   <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      gpio_q <= '0;
    end else begin
      sync_q <= sync_d;
      ps_q   <= ps_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      gpio_q <= gpio_d;
    end
  end

endmodule

// File: tb/tb_soc_gpio_input_filter.sv
// Bench for soc_gpio_input_filter: directed scenarios with literal expectations plus
// randomized pads/enables/resets compared every cycle against a behavioural model.
module tb_soc_gpio_input_filter;
  localparam int PC = 1;
  localparam int SS = 2;
  localparam int PS = 4;
  localparam int DC = 3;
  localparam int W  = 32 * PC;

  logic         clk = 1'b0;
  logic         res;
  logic [W-1:0] pin_in;
  logic [W-1:0] filter_en;
  logic [W-1:0] gpio_in;
  logic         sample_tick;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  soc_gpio_input_filter #(
    .PORT_COUNT  (PC),
    .SYNC_STAGES (SS),
    .PRESCALE    (PS),
    .DEBOUNCE_CNT(DC)
  ) dut (
    .clk        (clk),
    .res        (res),
    .pin_in     (pin_in),
    .filter_en  (filter_en),
    .gpio_in    (gpio_in),
    .sample_tick(sample_tick)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: pad samples history, edges since reset, per-pin run length of mismatching ticks.
  logic [W-1:0] m_pads [SS];
  logic [W-1:0] m_gpio;
  int           m_run [W];
  int           m_edges;
  logic         m_tick;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [W-1:0] seen;
    logic         tick_now;
    seen     = m_pads[SS-1];
    tick_now = (m_edges > 0) && (m_edges % PS == PS - 1);
    if (!res) begin
      for (int j = 0; j < SS; j++) m_pads[j] = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_gpio  = '0;
      m_edges = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!filter_en[i]) begin
          m_gpio[i] = seen[i];
          m_run[i]  = 0;
        end else if (tick_now) begin
          if (seen[i] == m_gpio[i]) m_run[i] = 0;
          else if (m_run[i] + 1 >= DC) begin
            m_gpio[i] = seen[i];
            m_run[i]  = 0;
          end else m_run[i] = m_run[i] + 1;
        end
      end
      for (int j = SS - 1; j > 0; j--) m_pads[j] = m_pads[j-1];
      m_pads[0] = pin_in;
      m_edges   = m_edges + 1;
    end
    m_tick  = (m_edges > 0) && (m_edges % PS == PS - 1);
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gpio", gpio_in, m_gpio);
      chk("model_tick", W'(sample_tick), W'(m_tick));
    end
  end

  // Returns at a negedge where sample_tick is high, so the next posedge is a tick edge.
  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_tick && k < 4 * PS);
    if (!sample_tick) begin
      tests++;
      fails++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", 4 * PS);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  rise;
    bit  seen_high;
    int  idx;

    // Reset with pads high.
    res       = 1'b0;
    pin_in    = '1;
    filter_en = '0;
    repeat (3) @(negedge clk);
    chk("rst_gpio", gpio_in, '0);
    chk("rst_tick", W'(sample_tick), W'(1'b0));
    res = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("boot_tick", W'(sample_tick), W'(n % 4 == 3));
      if (n == 2) chk("boot_gpio_early", gpio_in, '0);
      if (n == 3) chk("boot_gpio", gpio_in, 32'hFFFF_FFFF);
    end

    // Unfiltered step on pin 0.
    pin_in = '0;
    repeat (5) @(negedge clk);
    pin_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("unfilt_before", W'(gpio_in[0]), W'(1'b0));
    @(negedge clk);
    chk("unfilt_after", W'(gpio_in[0]), W'(1'b1));

    // Filtered step on pin 5.
    filter_en[5] = 1'b1;
    repeat (3) @(negedge clk);
    pin_in[5] = 1'b1;
    rise = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (gpio_in[5] && rise == 0) rise = n;
    end
    tests++;
    if (!(rise >= 11 && rise <= 14)) begin
      fails++;
      $display("FAIL filt_latency: rose after %0d edges, required 11..14", rise);
    end

    // Two back-to-back glitches of exactly two ticks each.
    pin_in[5] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_start", W'(gpio_in[5]), W'(1'b0));
    seen_high = 1'b0;
    for (int g = 0; g < 2; g++) begin
      wait_tick();
      pin_in[5] = 1'b1;
      repeat (8) begin
        @(negedge clk);
        seen_high |= gpio_in[5];
      end
      pin_in[5] = 1'b0;
    end
    repeat (20) begin
      @(negedge clk);
      seen_high |= gpio_in[5];
    end
    chk("glitch_reject", W'(seen_high), W'(1'b0));

    // Disable filter mid-count, then re-enable.
    wait_tick();
    pin_in[5] = 1'b1;
    repeat (9) @(negedge clk);
    chk("midcount_hold", W'(gpio_in[5]), W'(1'b0));
    filter_en[5] = 1'b0;
    @(negedge clk);
    chk("disable_passthru", W'(gpio_in[5]), W'(1'b1));
    filter_en[5] = 1'b1;
    seen_high = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen_high &= gpio_in[5];
    end
    chk("reenable_stable", W'(seen_high), W'(1'b1));

    // Reset mid-count with the pad still high.
    pin_in[5] = 1'b0;
    repeat (20) @(negedge clk);
    wait_tick();
    pin_in[5] = 1'b1;
    repeat (9) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("midrst_gpio", gpio_in, '0);
    chk("midrst_tick", W'(sample_tick), W'(1'b0));
    res  = 1'b1;
    rise = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (gpio_in[5] && rise == 0) rise = n;
    end
    chk("midrst_rise_edge", W'(rise), W'(12));

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      res = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) begin
        idx = $urandom_range(0, W - 1);
        pin_in[idx] = ~pin_in[idx];
      end
      if ($urandom_range(0, 149) == 0) filter_en = $urandom;
    end
    res = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
